// File: rtl/washer_ctrl_gen2.sv
// Washing-machine sequencer: fill, agitate (fwd/gap/rev/gap loops), drain, spin,
// with an emergency-stop HALT state. Phase timing is counted in one-per-second ticks.
module washer_ctrl_gen2 #(
    parameter int unsigned TW         = 6,
    parameter int unsigned T_FILL     = 60,
    parameter int unsigned T_RUN      = 60,
    parameter int unsigned T_GAP      = 5,
    parameter int unsigned T_DRAIN    = 60,
    parameter int unsigned T_SPIN     = 60,
    parameter int unsigned RW         = 4,
    parameter int unsigned WASH_REPS  = 7,
    parameter int unsigned RINSE_REPS = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic          estop,
    output logic          inlet,
    output logic          drain,
    output logic          dry,
    output logic          zheng,
    output logic          fan,
    output logic          ledstop,
    output logic          alarm,
    output logic          busy,
    output logic [3:0]    c_s,
    output logic [RW-1:0] reps_left
);

    localparam logic [3:0] S_IDLE  = 4'd0;
    localparam logic [3:0] S_FILL  = 4'd1;
    localparam logic [3:0] S_FWD   = 4'd2;
    localparam logic [3:0] S_GAP1  = 4'd3;
    localparam logic [3:0] S_REV   = 4'd4;
    localparam logic [3:0] S_GAP2  = 4'd5;
    localparam logic [3:0] S_DRAIN = 4'd6;
    localparam logic [3:0] S_SPIN  = 4'd7;
    localparam logic [3:0] S_DONE  = 4'd8;
    localparam logic [3:0] S_HALT  = 4'd9;

    logic [3:0]    state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [RW-1:0] reps_nxt;
    logic [1:0]    mode_q;
    logic [1:0]    mode_nxt;
    logic          first_q;
    logic          first_nxt;
    logic          inlet_nxt;
    logic          drain_nxt;
    logic          dry_nxt;
    logic          zheng_nxt;
    logic          fan_nxt;
    logic          ledstop_nxt;
    logic          alarm_nxt;
    logic          busy_nxt;

    // Final timer value of each timed phase; the phase ends on the tick that reaches it.
    function automatic logic [TW-1:0] last_count(input logic [3:0] st);
        case (st)
            S_FILL:         last_count = TW'(T_FILL - 1);
            S_FWD, S_REV:   last_count = TW'(T_RUN - 1);
            S_GAP1, S_GAP2: last_count = TW'(T_GAP - 1);
            S_DRAIN:        last_count = TW'(T_DRAIN - 1);
            S_SPIN:         last_count = TW'(T_SPIN - 1);
            default:        last_count = '0;
        endcase
    endfunction

    // State, timer, pass bookkeeping and registered drive outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_s       <= S_IDLE;
            timer     <= '0;
            reps_left <= '0;
            mode_q    <= 2'd0;
            first_q   <= 1'b0;
            inlet     <= 1'b0;
            drain     <= 1'b0;
            dry       <= 1'b0;
            zheng     <= 1'b0;
            fan       <= 1'b0;
            ledstop   <= 1'b1;
            alarm     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            c_s       <= state_nxt;
            timer     <= timer_nxt;
            reps_left <= reps_nxt;
            mode_q    <= mode_nxt;
            first_q   <= first_nxt;
            inlet     <= inlet_nxt;
            drain     <= drain_nxt;
            dry       <= dry_nxt;
            zheng     <= zheng_nxt;
            fan       <= fan_nxt;
            ledstop   <= ledstop_nxt;
            alarm     <= alarm_nxt;
            busy      <= busy_nxt;
        end
    end

    // Next-state, timer and repetition logic; estop overrides every phase advance.
    always_comb begin
        state_nxt = c_s;
        timer_nxt = timer;
        reps_nxt  = reps_left;
        mode_nxt  = mode_q;
        first_nxt = first_q;
        if (estop) begin
            state_nxt = S_HALT;
            timer_nxt = '0;
            reps_nxt  = '0;
        end else begin
            case (c_s)
                S_IDLE: begin
                    if (start && (mode != 2'd0)) begin
                        mode_nxt  = mode;
                        first_nxt = 1'b1;
                        timer_nxt = '0;
                        if (mode == 2'd3) begin
                            state_nxt = S_DRAIN;
                        end else begin
                            state_nxt = S_FILL;
                            reps_nxt  = (mode == 2'd2) ? RW'(WASH_REPS) : RW'(RINSE_REPS);
                        end
                    end
                end
                S_FILL, S_FWD, S_GAP1, S_REV, S_GAP2, S_DRAIN, S_SPIN: begin
                    if (tick) begin
                        if (timer == last_count(c_s)) begin
                            timer_nxt = '0;
                            case (c_s)
                                S_FILL: state_nxt = S_FWD;
                                S_FWD:  state_nxt = S_GAP1;
                                S_GAP1: state_nxt = S_REV;
                                S_REV:  state_nxt = S_GAP2;
                                S_GAP2: begin
                                    reps_nxt  = reps_left - 1'b1;
                                    state_nxt = (reps_left != RW'(1)) ? S_FWD : S_DRAIN;
                                end
                                S_DRAIN: begin
                                    // A full wash drains into a second fill for its rinse pass.
                                    if ((mode_q == 2'd2) && first_q) begin
                                        state_nxt = S_FILL;
                                        first_nxt = 1'b0;
                                        reps_nxt  = RW'(RINSE_REPS);
                                    end else begin
                                        state_nxt = S_SPIN;
                                    end
                                end
                                S_SPIN:  state_nxt = S_DONE;
                                default: state_nxt = S_IDLE;
                            endcase
                        end else begin
                            timer_nxt = timer + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (start) state_nxt = S_IDLE;
                end
                S_HALT:  state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Drive decode from the next state so the output registers track c_s exactly.
    always_comb begin
        inlet_nxt   = 1'b0;
        drain_nxt   = 1'b0;
        dry_nxt     = 1'b0;
        zheng_nxt   = 1'b0;
        fan_nxt     = 1'b0;
        ledstop_nxt = 1'b0;
        alarm_nxt   = 1'b0;
        busy_nxt    = 1'b0;
        case (state_nxt)
            S_IDLE:  ledstop_nxt = 1'b1;
            S_FILL:  begin inlet_nxt = 1'b1; busy_nxt = 1'b1; end
            S_FWD:   begin zheng_nxt = 1'b1; busy_nxt = 1'b1; end
            S_GAP1:  begin ledstop_nxt = 1'b1; busy_nxt = 1'b1; end
            S_REV:   begin fan_nxt = 1'b1; busy_nxt = 1'b1; end
            S_GAP2:  begin ledstop_nxt = 1'b1; busy_nxt = 1'b1; end
            S_DRAIN: begin drain_nxt = 1'b1; busy_nxt = 1'b1; end
            S_SPIN:  begin drain_nxt = 1'b1; dry_nxt = 1'b1; busy_nxt = 1'b1; end
            S_DONE:  begin ledstop_nxt = 1'b1; alarm_nxt = 1'b1; end
            S_HALT:  begin ledstop_nxt = 1'b1; alarm_nxt = 1'b1; end
            default: ledstop_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_washer_ctrl_gen2.sv
// Bench for washer_ctrl_gen2: directed vector table, multi-cycle sequences, and a
// randomized run checked against a phase-plan reference model.
module tb_washer_ctrl_gen2;

    localparam int T_FILL = 60, T_RUN = 60, T_GAP = 5, T_DRAIN = 60, T_SPIN = 60;
    localparam int WASH_REPS = 7, RINSE_REPS = 15, RW = 4;

    localparam logic [3:0] S_IDLE = 4'd0, S_FILL = 4'd1, S_FWD = 4'd2, S_GAP1 = 4'd3,
                           S_REV = 4'd4, S_GAP2 = 4'd5, S_DRAIN = 4'd6, S_SPIN = 4'd7,
                           S_DONE = 4'd8, S_HALT = 4'd9;

    logic clk = 1'b0;
    logic rst, tick, start, estop;
    logic [1:0] mode;
    logic inlet, drain, dry, zheng, fan, ledstop, alarm, busy;
    logic [3:0] c_s;
    logic [RW-1:0] reps_left;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    washer_ctrl_gen2 #(
        .TW(6), .T_FILL(T_FILL), .T_RUN(T_RUN), .T_GAP(T_GAP), .T_DRAIN(T_DRAIN),
        .T_SPIN(T_SPIN), .RW(RW), .WASH_REPS(WASH_REPS), .RINSE_REPS(RINSE_REPS)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .mode(mode), .estop(estop),
        .inlet(inlet), .drain(drain), .dry(dry), .zheng(zheng), .fan(fan),
        .ledstop(ledstop), .alarm(alarm), .busy(busy), .c_s(c_s), .reps_left(reps_left)
    );

    always #5 clk = ~clk;

    // Expected {inlet,drain,dry,zheng,fan,ledstop,alarm,busy} for each state.
    function automatic logic [7:0] exp_drive(input logic [3:0] st);
        case (st)
            S_IDLE:  return 8'b0000_0100;
            S_FILL:  return 8'b1000_0001;
            S_FWD:   return 8'b0001_0001;
            S_GAP1:  return 8'b0000_0101;
            S_REV:   return 8'b0000_1001;
            S_GAP2:  return 8'b0000_0101;
            S_DRAIN: return 8'b0100_0001;
            S_SPIN:  return 8'b0110_0001;
            S_DONE:  return 8'b0000_0110;
            S_HALT:  return 8'b0000_0110;
            default: return 8'hxx;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [3:0] ecs, input int erps);
        logic [7:0] act_o, exp_o;
        act_o = {inlet, drain, dry, zheng, fan, ledstop, alarm, busy};
        exp_o = exp_drive(ecs);
        vectors++;
        if (c_s !== ecs || reps_left !== RW'(erps) || act_o !== exp_o) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got c_s=%0d reps=%0d outs=%b, expected c_s=%0d reps=%0d outs=%b",
                     nm, cyc, c_s, reps_left, act_o, ecs, erps, exp_o);
        end
    endtask

    task automatic chk_val(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Apply one cycle of inputs and sample #1 after the rising edge.
    task automatic step(input logic r, input logic t, input logic s, input logic [1:0] m,
                        input logic e);
        rst = r; tick = t; start = s; mode = m; estop = e;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic tstep(input int div);
        step(1'b0, (cyc % div) == 0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic run_while(input logic [3:0] st, input int div, output int n);
        n = 0;
        while (c_s === st && n < 20000) begin
            n++;
            tstep(div);
        end
    endtask

    // ---------------- reference model: a run is a flat list of timed phases ----------------
    typedef struct { logic [3:0] st; int dur; int reps; } phase_t;
    phase_t plan[$];
    int m_st;            // 0 idle, 1 running, 2 done, 3 halt
    int m_idx, m_tc;

    task automatic add_phase(input logic [3:0] st, input int dur, input int reps);
        phase_t p;
        p.st = st; p.dur = dur; p.reps = reps;
        plan.push_back(p);
    endtask

    task automatic add_pass(input int n);
        add_phase(S_FILL, T_FILL, n);
        for (int r = n; r >= 1; r--) begin
            add_phase(S_FWD, T_RUN, r);
            add_phase(S_GAP1, T_GAP, r);
            add_phase(S_REV, T_RUN, r);
            add_phase(S_GAP2, T_GAP, r);
        end
        add_phase(S_DRAIN, T_DRAIN, 0);
    endtask

    task automatic build_plan(input logic [1:0] m);
        plan.delete();
        if (m == 2'd3) add_phase(S_DRAIN, T_DRAIN, 0);
        else if (m == 2'd2) begin add_pass(WASH_REPS); add_pass(RINSE_REPS); end
        else add_pass(RINSE_REPS);
        add_phase(S_SPIN, T_SPIN, 0);
    endtask

    task automatic m_update(input logic r, input logic t, input logic s, input logic [1:0] m,
                            input logic e);
        if (r) m_st = 0;
        else if (e) m_st = 3;
        else case (m_st)
            0: if (s && m != 2'd0) begin build_plan(m); m_idx = 0; m_tc = 0; m_st = 1; end
            1: if (t) begin
                   m_tc++;
                   if (m_tc == plan[m_idx].dur) begin
                       m_idx++; m_tc = 0;
                       if (m_idx == plan.size()) m_st = 2;
                   end
               end
            2: if (s) m_st = 0;
            default: m_st = 0;
        endcase
    endtask

    function automatic logic [3:0] m_cs();
        case (m_st)
            0: return S_IDLE;
            1: return plan[m_idx].st;
            2: return S_DONE;
            default: return S_HALT;
        endcase
    endfunction

    function automatic int m_reps();
        return (m_st == 1) ? plan[m_idx].reps : 0;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic r; logic t; logic s; logic [1:0] m; logic e;
        logic [3:0] ecs; int erps;
    } vec_t;
    vec_t tbl[14];

    initial begin
        int n, fwd_n, rev_n, fill_n, drain_n, seq_bad, busy_n, guard;
        logic [3:0] prev;
        logic r, t, s, e;
        logic [1:0] m;
        int estop_cnt;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, S_IDLE, 0};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, S_IDLE, 0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 2'd3, 1'b0, S_DRAIN, 0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, S_DRAIN, 0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b1, S_HALT, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, S_HALT, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, S_IDLE, 0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, S_FILL, 15};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, S_FILL, 15};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, S_HALT, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, S_IDLE, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, S_FILL, 7};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 2'd2, 1'b0, S_IDLE, 0};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, S_IDLE, 0};

        rst = 1'b1; tick = 1'b0; start = 1'b0; mode = 2'd0; estop = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].m, tbl[i].e);
            chk($sformatf("table[%0d]", i), tbl[i].ecs, tbl[i].erps);
        end

        // Spin-only run with a tick every cycle.
        step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
        chk("m3_drain_entry", S_DRAIN, 0);
        run_while(S_DRAIN, 1, n);
        chk_val("m3_drain_ticks", n, 60);
        run_while(S_SPIN, 1, n);
        chk_val("m3_spin_ticks", n, 60);
        chk("m3_done", S_DONE, 0);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("m3_done_hold", S_DONE, 0);
        step(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        chk("m3_done_to_idle", S_IDLE, 0);

        // Rinse run: 15 agitation cycles counting down.
        step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        chk("m1_fill_entry", S_FILL, 15);
        fwd_n = 0; rev_n = 0; seq_bad = 0; guard = 0; prev = c_s;
        while (c_s !== S_DRAIN && guard < 5000) begin
            tstep(1);
            guard++;
            if (c_s === S_FWD && prev !== S_FWD) begin
                if (reps_left !== RW'(15 - fwd_n)) seq_bad++;
                fwd_n++;
            end
            if (c_s === S_REV && prev !== S_REV) rev_n++;
            prev = c_s;
        end
        chk_val("m1_fwd_cycles", fwd_n, 15);
        chk_val("m1_rev_cycles", rev_n, 15);
        chk_val("m1_reps_sequence_errors", seq_bad, 0);
        chk("m1_drain_entry", S_DRAIN, 0);
        run_while(S_DRAIN, 1, n);
        chk("m1_spin_entry", S_SPIN, 0);
        run_while(S_SPIN, 1, n);
        chk("m1_done", S_DONE, 0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        chk("m1_to_idle", S_IDLE, 0);

        // Full wash: wash pass, rinse pass, spin; busy time equals the sum of phases.
        step(1'b0, 1'b1, 1'b1, 2'd2, 1'b0);
        chk("m2_fill_entry", S_FILL, 7);
        busy_n = 1; fill_n = 1; drain_n = 0; fwd_n = 0; guard = 0; prev = c_s;
        while (c_s !== S_DONE && guard < 10000) begin
            tstep(1);
            guard++;
            if (c_s >= S_FILL && c_s <= S_SPIN) busy_n++;
            if (c_s === S_FILL && prev !== S_FILL) begin
                fill_n++;
                chk("m2_rinse_fill", S_FILL, 15);
            end
            if (c_s === S_DRAIN && prev !== S_DRAIN) drain_n++;
            if (c_s === S_FWD && prev !== S_FWD) fwd_n++;
            prev = c_s;
        end
        chk_val("m2_busy_ticks", busy_n,
                2 * T_FILL + 22 * (2 * T_RUN + 2 * T_GAP) + 2 * T_DRAIN + T_SPIN);
        chk_val("m2_fill_count", fill_n, 2);
        chk_val("m2_drain_count", drain_n, 2);
        chk_val("m2_fwd_count", fwd_n, 22);
        chk("m2_done", S_DONE, 0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        chk("m2_to_idle", S_IDLE, 0);

        // Emergency stop in the middle of forward drive.
        step(1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        run_while(S_FILL, 1, n);
        chk("es_fwd", S_FWD, 15);
        tstep(1); tstep(1); tstep(1);
        step(1'b0, 1'b1, 1'b0, 2'd0, 1'b1);
        chk("es_halt", S_HALT, 0);
        step(1'b0, 1'b1, 1'b1, 2'd2, 1'b1);
        chk("es_halt_hold", S_HALT, 0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("es_release", S_IDLE, 0);

        // Sparse tick: phases stretch four-fold.
        step(1'b0, 1'b0, 1'b1, 2'd3, 1'b0);
        run_while(S_DRAIN, 4, n);
        chk_val("sparse_drain_in_range", int'(n >= 237 && n <= 240), 1);
        run_while(S_SPIN, 4, n);
        chk_val("sparse_spin_clks", n, 240);
        chk("sparse_done", S_DONE, 0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0);

        // Reset in the middle of spin.
        step(1'b0, 1'b1, 1'b1, 2'd3, 1'b0);
        run_while(S_DRAIN, 1, n);
        tstep(1); tstep(1); tstep(1);
        chk("rst_pre_spin", S_SPIN, 0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        chk("rst_mid_spin", S_IDLE, 0);

        // Randomized run against the phase-plan model.
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        m_update(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        chk("rand_reset", m_cs(), m_reps());
        estop_cnt = 0;
        for (int k = 0; k < 30000; k++) begin
            r = ($urandom_range(0, 4999) == 0);
            if (estop_cnt > 0) begin
                e = 1'b1;
                estop_cnt--;
            end else if ($urandom_range(0, 1499) == 0) begin
                e = 1'b1;
                estop_cnt = $urandom_range(0, 3);
            end else begin
                e = 1'b0;
            end
            t = ($urandom_range(0, 9) != 0);
            s = ($urandom_range(0, 15) == 0);
            m = 2'($urandom_range(0, 3));
            step(r, t, s, m, e);
            m_update(r, t, s, m, e);
            chk("rand", m_cs(), m_reps());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/washer_ctrl_gen2.md
WASHER_CTRL_GEN2 -- requirements
Module: washer_ctrl_gen2

Interface
REQ-001 The block SHALL have parameter TW, default 6, meaning phase-timer width in bits.
REQ-002 The block SHALL have parameter T_FILL, default 60, meaning fill-phase duration in ticks.
REQ-003 The block SHALL have parameter T_RUN, default 60, meaning forward or reverse drive duration in ticks.
REQ-004 The block SHALL have parameter T_GAP, default 5, meaning motor-stop gap duration in ticks.
REQ-005 The block SHALL have parameter T_DRAIN, default 60, meaning drain-phase duration in ticks.
REQ-006 The block SHALL have parameter T_SPIN, default 60, meaning spin-phase duration in ticks.
REQ-007 The block SHALL have parameter RW, default 4, meaning repetition-counter width in bits.
REQ-008 The block SHALL have parameter WASH_REPS, default 7, meaning agitation cycles in the wash pass.
REQ-009 The block SHALL have parameter RINSE_REPS, default 15, meaning agitation cycles in a rinse pass.
REQ-010 The block SHALL have port clk, input, 1 bit: the only clock; all logic on its rising edge.
REQ-011 The block SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-012 The block SHALL have port tick, input, 1 bit: one-clk strobe, one per second.
REQ-013 The block SHALL have port start, input, 1 bit: one-clk request strobe.
REQ-014 The block SHALL have port mode, input, 2 bits: 0 none, 1 rinse, 2 full wash, 3 spin only.
REQ-015 The block SHALL have port estop, input, 1 bit: emergency stop, level, active-high.
REQ-016 The block SHALL have outputs inlet, drain, dry, zheng and fan, 1 bit each: valve and motor drives.
REQ-017 The block SHALL have port ledstop, output, 1 bit: high in IDLE, GAP, DONE and HALT.
REQ-018 The block SHALL have port alarm, output, 1 bit: high in DONE and HALT.
REQ-019 The block SHALL have port busy, output, 1 bit: high in every state except IDLE, DONE and HALT.
REQ-020 The block SHALL have port c_s, output, 4 bits: current state encoding.
REQ-021 The block SHALL have port reps_left, output, RW bits: agitation cycles remaining.

Function
REQ-022 The state encodings SHALL be IDLE=0, FILL=1, FWD=2, GAP1=3, REV=4, GAP2=5, DRAIN=6, SPIN=7, DONE=8, HALT=9.
REQ-023 All outputs SHALL be registered and SHALL be a pure function of the registered state.
REQ-024 The drives SHALL be asserted as: FILL inlet; FWD zheng; REV fan; DRAIN drain; SPIN drain and dry; all other states none.
REQ-025 The phase timer SHALL increment only on cycles with tick=1.
REQ-026 On the tick where the phase timer equals duration-1, the state SHALL advance and the timer SHALL clear to 0.
REQ-027 On entry to any state the phase timer SHALL be 0.
REQ-028 In IDLE, start=1 with mode!=0 SHALL latch mode, set the pass counter and go to FILL, or to DRAIN for mode 3.
REQ-029 In IDLE, start=1 with mode=0 SHALL be ignored.
REQ-030 On entry to FILL, reps_left SHALL load WASH_REPS for a mode-2 first pass, otherwise RINSE_REPS.
REQ-031 The agitation loop SHALL be FILL->FWD->GAP1->REV->GAP2.
REQ-032 Leaving GAP2, reps_left SHALL decrement; if the result is nonzero the next state SHALL be FWD, otherwise DRAIN.
REQ-033 Leaving DRAIN, a mode-2 first pass SHALL go to FILL for the rinse pass; all other cases SHALL go to SPIN.
REQ-034 Leaving SPIN, the next state SHALL be DONE.
REQ-035 In DONE, alarm SHALL hold until start=1, which SHALL return to IDLE without launching a run.
REQ-036 The start and mode inputs SHALL be ignored outside IDLE and DONE, and the latched mode SHALL NOT change mid-run.
REQ-037 estop=1 in any state SHALL enter HALT on the next cycle, clearing the phase timer and reps_left.
REQ-038 HALT SHALL hold while estop=1 and SHALL go to IDLE on the first cycle with estop=0.
REQ-039 Priority SHALL be rst > estop > tick/start; estop and tick in the same cycle SHALL NOT advance the phase.
REQ-040 WASH_REPS and RINSE_REPS SHALL fit RW bits and be at least 1, and all durations SHALL be at least 1 and fit TW bits.

Reset
REQ-041 rst=1 SHALL force, on the next edge, c_s=IDLE, ledstop=1, all other outputs 0, reps_left=0, timer=0 and latched mode=0.
REQ-042 rst SHALL override any state, including mid-phase, DONE and HALT.

Verification
REQ-043 Mode 3 with tick every cycle SHALL produce DRAIN for 60 ticks, SPIN for 60 ticks, then DONE with alarm=1 and busy=0.
REQ-044 Mode 1 with defaults SHALL produce exactly 15 FWD/REV cycles, with reps_left reading 15..1 and 0 at DRAIN entry, then SPIN and DONE.
REQ-045 Mode 2 SHALL produce FILL, 7 cycles, DRAIN, FILL, 15 cycles, DRAIN, SPIN, DONE, with total ticks matching the parameter sum.
REQ-046 estop asserted mid-FWD SHALL give HALT next cycle with zheng=0, alarm=1 and reps_left=0; estop release SHALL give IDLE.
REQ-047 start with mode=0, and start during a run, SHALL cause no state change.
REQ-048 rst during SPIN SHALL give IDLE with all drives 0 on the next edge; a sparse tick (every 4 clk) SHALL scale phase lengths 4x.
